// File: rtl/tlc_phase_scheduler.sv
// Timed six-phase traffic-light sequencer for a highway / farm-road intersection.
// Each phase dwells for a programmable number of prescaled ticks. A latched
// farm-road sensor lets the highway leave green once its minimum time is up.
module tlc_phase_scheduler #(
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  sensor_i,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [CNT_W-1:0]      cfg_wdata,
  output logic [2:0]            light_highway,
  output logic [2:0]            light_farm,
  output logic [2:0]            phase_o,
  output logic                  tick_o,
  output logic                  cycle_done_o
);

  typedef enum logic [2:0] {
    HGRE    = 3'd0,
    HYEL    = 3'd1,
    ALLRED1 = 3'd2,
    FGRE    = 3'd3,
    FYEL    = 3'd4,
    ALLRED2 = 3'd5
  } phase_t;

  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);
  localparam logic [CNT_W-1:0]      HGREEN_RST = CNT_W'(10);
  localparam logic [CNT_W-1:0]      HYEL_RST   = CNT_W'(3);
  localparam logic [CNT_W-1:0]      ALLRED_RST = CNT_W'(1);
  localparam logic [CNT_W-1:0]      FGREEN_RST = CNT_W'(8);
  localparam logic [CNT_W-1:0]      FYEL_RST   = CNT_W'(3);

  phase_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    latch_q;
  logic [CNT_W-1:0]        hgreen_min_q, hyel_q, allred_q, fgreen_max_q, fyel_q;
  logic                    tick, expiry, advance;
  logic [CNT_W-1:0]        next_dur, load_val;

  // A tick only exists while running and outside reset.
  assign tick   = enable_i && !wb_rst_i && (presc_q == prescale_i);
  assign expiry = tick && (cnt_q == '0);
  assign tick_o = tick;

  // Prescaler: counts 0..prescale_i, parks at 0 while disabled; a count that
  // overshoots a freshly lowered prescale_i wraps without producing a tick.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (wb_rst_i || !enable_i) begin
      presc_q <= '0;
    end else if (presc_q >= prescale_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_ONE;
    end
  end

  // Next-phase selection, duration to load on entry, and light decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d       = state_q;
    advance       = 1'b0;
    next_dur      = hgreen_min_q;
    light_highway = 3'b100;
    light_farm    = 3'b100;
    unique case (state_q)
      HGRE: begin
        light_highway = 3'b001;
        advance       = expiry && (latch_q || sensor_i);
        state_d       = advance ? HYEL : HGRE;
        next_dur      = hyel_q;
      end
      HYEL: begin
        light_highway = 3'b010;
        advance       = expiry;
        state_d       = advance ? ALLRED1 : HYEL;
        next_dur      = allred_q;
      end
      ALLRED1: begin
        advance  = expiry;
        state_d  = advance ? FGRE : ALLRED1;
        next_dur = fgreen_max_q;
      end
      FGRE: begin
        light_farm = 3'b001;
        // The farm road gives up green as soon as nobody is waiting.
        advance    = expiry || (tick && !sensor_i);
        state_d    = advance ? FYEL : FGRE;
        next_dur   = fyel_q;
      end
      FYEL: begin
        light_farm = 3'b010;
        advance    = expiry;
        state_d    = advance ? ALLRED2 : FYEL;
        next_dur   = allred_q;
      end
      ALLRED2: begin
        advance  = expiry;
        state_d  = advance ? HGRE : ALLRED2;
        next_dur = hgreen_min_q;
      end
      default: begin
        advance  = 1'b1;
        state_d  = HGRE;
        next_dur = hgreen_min_q;
      end
    endcase
    // A zero duration behaves as a single tick.
    load_val = (next_dur == '0) ? '0 : next_dur - CNT_ONE;
    if (advance) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign phase_o      = state_q;
  assign cycle_done_o = advance && (state_q == ALLRED2);

  // Phase state and dwell down-counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= HGRE;
      cnt_q   <= HGREEN_RST - CNT_ONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Farm-road demand latch: set outside farm green, cleared on entering it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      latch_q <= 1'b0;
    end else if (advance && (state_q == ALLRED1)) begin
      latch_q <= 1'b0;
    end else if (sensor_i && (state_q != FGRE)) begin
      latch_q <= 1'b1;
    end
  end

  // Duration registers; a write is seen from the next cycle onward.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: these configuration registers are reset explicitly to usable
    // defaults, unlike a data memory, so the sequencer runs out of reset.
    if (wb_rst_i) begin
      hgreen_min_q <= HGREEN_RST;
      hyel_q       <= HYEL_RST;
      allred_q     <= ALLRED_RST;
      fgreen_max_q <= FGREEN_RST;
      fyel_q       <= FYEL_RST;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    hgreen_min_q <= cfg_wdata;
        3'd1:    hyel_q       <= cfg_wdata;
        3'd2:    allred_q     <= cfg_wdata;
        3'd3:    fgreen_max_q <= cfg_wdata;
        3'd4:    fyel_q       <= cfg_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Scoreboard bench for tlc_phase_scheduler. A phase-level reference model
// (phase index, ticks left in the phase, demand flag) predicts every cycle's
// outputs; a negedge monitor compares the DUT against the queued predictions.
module tb_tlc_phase_scheduler;

  localparam int CNT_W      = 8;
  localparam int PRESCALE_W = 16;

  logic                  wb_clk_i = 1'b0;
  logic                  wb_rst_i;
  logic                  enable_i;
  logic [PRESCALE_W-1:0] prescale_i;
  logic                  sensor_i;
  logic                  cfg_we;
  logic [2:0]            cfg_addr;
  logic [CNT_W-1:0]      cfg_wdata;
  logic [2:0]            light_highway;
  logic [2:0]            light_farm;
  logic [2:0]            phase_o;
  logic                  tick_o;
  logic                  cycle_done_o;

  tlc_phase_scheduler #(.CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .enable_i      (enable_i),
    .prescale_i    (prescale_i),
    .sensor_i      (sensor_i),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .light_highway (light_highway),
    .light_farm    (light_farm),
    .phase_o       (phase_o),
    .tick_o        (tick_o),
    .cycle_done_o  (cycle_done_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [2:0] hw;
    logic [2:0] fm;
    logic [2:0] ph;
    logic       tick;
    logic       cd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model: phase index, ticks still to serve in this phase,
  // farm demand flag, prescaler position and the five durations.
  int   m_ph;
  int   m_left;
  int   m_pc;
  bit   m_latch;
  int   m_cfg[5];
  bit   m_valid = 1'b0;

  int   cyc_idx  = 0;
  int   first_cd = 0;
  int   cd_count = 0;

  logic [2:0] hw_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] fm_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_idx);
    end
  endtask

  function automatic int dur_of(int p);
    case (p)
      0:       return m_cfg[0];
      1:       return m_cfg[1];
      3:       return m_cfg[3];
      4:       return m_cfg[4];
      default: return m_cfg[2];
    endcase
  endfunction

  task automatic model_reset();
    m_ph    = 0;
    m_cfg   = '{10, 3, 1, 8, 3};
    m_left  = 10;
    m_latch = 1'b0;
    m_pc    = 0;
  endtask

  // Predict this cycle from the driven inputs, queue it, advance the model,
  // then let the clock edge happen.
  task automatic cycle();
    exp_t e;
    bit   tk, expiry, adv;
    int   d;
    if (wb_rst_i) cyc_idx = 0;
    else          cyc_idx++;
    if (m_valid) begin
      tk     = enable_i && !wb_rst_i && (m_pc == int'(prescale_i));
      expiry = tk && (m_left == 1);
      case (m_ph)
        0:       adv = expiry && (m_latch || sensor_i);
        3:       adv = expiry || (tk && !sensor_i);
        default: adv = expiry;
      endcase
      e.hw   = hw_tab[m_ph];
      e.fm   = fm_tab[m_ph];
      e.ph   = 3'(m_ph);
      e.tick = tk;
      e.cd   = adv && (m_ph == 5);
      exp_q.push_back(e);
      if (!wb_rst_i) begin
        if (adv && m_ph == 2)            m_latch = 1'b0;
        else if (sensor_i && m_ph != 3)  m_latch = 1'b1;
        if (adv) begin
          m_ph   = (m_ph + 1) % 6;
          d      = dur_of(m_ph);
          m_left = (d == 0) ? 1 : d;
        end else if (tk && m_left > 1) begin
          m_left--;
        end
        if (!enable_i)                        m_pc = 0;
        else if (m_pc >= int'(prescale_i))    m_pc = 0;
        else                                  m_pc++;
        if (cfg_we && cfg_addr < 3'd5) m_cfg[cfg_addr] = int'(cfg_wdata);
      end
    end
    if (wb_rst_i) begin
      model_reset();
      m_valid = 1'b1;
    end
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic cfg_write(int addr, int data);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(addr);
    cfg_wdata = 8'(data);
    cycle();
    cfg_we    = 1'b0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    cycle();
    wb_rst_i = 1'b0;
  endtask

  // Run until the model reaches a phase (and optionally a ticks-left value).
  task automatic run_until(int ph, int left, int budget);
    int n = 0;
    while (!(m_ph == ph && (left < 0 || m_left == left)) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("wait_budget", 32'(n), 32'(budget - 1));
  endtask

  // Monitor: compare the DUT against the oldest prediction each cycle.
  always @(negedge wb_clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("light_highway", 32'(light_highway), 32'(e.hw));
      check("light_farm",    32'(light_farm),    32'(e.fm));
      check("phase_o",       32'(phase_o),       32'(e.ph));
      check("tick_o",        32'(tick_o),        32'(e.tick));
      check("cycle_done_o",  32'(cycle_done_o),  32'(e.cd));
      check("no_conflict",   32'(light_highway[2] | light_farm[2]), 32'd1);
    end
    if (cycle_done_o === 1'b1) begin
      cd_count++;
      if (first_cd == 0) first_cd = cyc_idx;
    end
  end

  initial begin
    wb_rst_i   = 1'b1;
    enable_i   = 1'b1;
    prescale_i = '0;
    sensor_i   = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    do_reset();

    // No farm demand: the highway keeps green indefinitely.
    cd_count = 0;
    repeat (50) cycle();
    check("t1_no_cycle_done", 32'(cd_count), 32'd0);
    check("t1_still_hgre", 32'(phase_o), 32'd0);

    // Full cycle at one tick per clock: ALLRED2 -> HGRE on post-reset cycle 26.
    do_reset();
    first_cd = 0;
    for (int n = 1; n <= 40; n++) begin
      sensor_i = (n >= 2);
      cycle();
    end
    check("t2_cycle_done_cycle", 32'(first_cd), 32'd26);

    // Prescaled ticks with a single sensor pulse; farm green ends at first tick.
    prescale_i = 16'd4;
    sensor_i   = 1'b0;
    do_reset();
    repeat (7) cycle();
    sensor_i = 1'b1;
    cycle();
    sensor_i = 1'b0;
    repeat (150) cycle();

    // Reprogrammed durations; a write during FYEL does not alter that dwell.
    prescale_i = '0;
    do_reset();
    cfg_write(1, 0);
    cfg_write(3, 2);
    sensor_i = 1'b1;
    run_until(4, -1, 100);
    cfg_write(4, 7);
    repeat (40) cycle();

    // Reset in the middle of farm green restores the default durations.
    prescale_i = 16'd3;
    do_reset();
    cfg_write(3, 2);
    run_until(3, -1, 200);
    cycle();
    do_reset();
    check("t5_phase_after_reset", 32'(phase_o), 32'd0);
    check("t5_hw_after_reset", 32'(light_highway), 32'h1);
    run_until(3, -1, 200);
    repeat (60) cycle();

    // Freeze during yellow with one tick outstanding beyond the current one.
    prescale_i = 16'd2;
    do_reset();
    run_until(1, 2, 200);
    enable_i = 1'b0;
    repeat (20) cycle();
    enable_i = 1'b1;
    repeat (30) cycle();

    // Randomised operation.
    sensor_i = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      wb_rst_i = ($urandom_range(0, 499) == 0);
      enable_i = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) prescale_i = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0)  sensor_i   = ~sensor_i;
      cfg_we = ($urandom_range(0, 19) == 0);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_wdata = 8'($urandom_range(0, 5));
      cycle();
    end
    wb_rst_i = 1'b0;
    cfg_we   = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
